// File: rtl/max_count_sched.sv
// Two-client max-and-count scheduler: grants A or B (round-robin on contention), pulses out_<gnt> for max(x,y) cycles.
// Grant takes one edge; pulses start at the edge the granted dav is seen low; rfd stays low (work refused) until the train ends.
module max_count_sched (
  input  logic       clock,
  input  logic       reset_,
  output logic       rfd_a,
  input  logic       dav_a,
  input  logic [7:0] xa,
  input  logic [7:0] ya,
  output logic       rfd_b,
  input  logic       dav_b,
  input  logic [7:0] xb,
  input  logic [7:0] yb,
  output logic       out_a,
  output logic       out_b,
  output logic       busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] EMIT = 2'd2;

  logic [1:0] star;
  logic [7:0] count;
  logic       gnt;
  logic       pri;
  logic       win_b;
  logic [7:0] win_max;
  logic       gnt_dav;

  function automatic logic [7:0] max8(input logic [7:0] x, input logic [7:0] y);
    return (x < y) ? y : x;
  endfunction

  // Under contention the priority pointer picks; otherwise whichever dav is up.
  assign win_b   = (dav_a & dav_b) ? pri : dav_b;
  assign win_max = win_b ? max8(xb, yb) : max8(xa, ya);
  assign gnt_dav = gnt ? dav_b : dav_a;
  assign busy    = (star != IDLE);

  always_ff @(posedge clock) begin
    if (!reset_) begin
      star  <= IDLE;
      rfd_a <= 1'b1;
      rfd_b <= 1'b1;
      out_a <= 1'b0;
      out_b <= 1'b0;
      count <= 8'd0;
      gnt   <= 1'b0;
      pri   <= 1'b0;
    end else begin
      case (star)
        IDLE: begin
          rfd_a <= 1'b1;
          rfd_b <= 1'b1;
          if (dav_a | dav_b) begin
            gnt   <= win_b;
            count <= win_max;
            rfd_a <= 1'b0;
            rfd_b <= 1'b0;
            star  <= WAIT;
          end
        end
        WAIT: begin
          if (!gnt_dav) begin
            if (count == 8'd0) begin
              rfd_a <= 1'b1;
              rfd_b <= 1'b1;
              pri   <= ~gnt;
              star  <= IDLE;
            end else begin
              out_a <= ~gnt;
              out_b <= gnt;
              star  <= EMIT;
            end
          end
        end
        EMIT: begin
          // Count never reaches zero here: a zero count returns from WAIT directly.
          if (count == 8'd1) begin
            out_a <= 1'b0;
            out_b <= 1'b0;
            rfd_a <= 1'b1;
            rfd_b <= 1'b1;
            pri   <= ~gnt;
            star  <= IDLE;
          end else begin
            count <= count - 8'd1;
          end
        end
        default: begin
          star  <= IDLE;
          out_a <= 1'b0;
          out_b <= 1'b0;
          rfd_a <= 1'b1;
          rfd_b <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_max_count_sched.sv
// Bench for max_count_sched: service-level model (who is served, pulses left) checked every cycle,
// plus directed scenarios with literal pulse counts and service order.
module tb_max_count_sched;

  logic       clock = 1'b0;
  logic       reset_;
  logic       rfd_a, rfd_b, out_a, out_b, busy;
  logic       dav_a, dav_b;
  logic [7:0] xa, ya, xb, yb;

  int checks   = 0;
  int failures = 0;

  // Model: requester being served (-1 none), whether it has released, pulses still owed.
  int m_pend = -1;
  bit m_rel  = 1'b0;
  int m_left = 0;
  bit m_pri  = 1'b0;

  int   pulses_a = 0, pulses_b = 0, order = 0;
  logic prev_a = 1'b0, prev_b = 1'b0;
  int   hold_a = 0, hold_b = 0;
  bit   scramble = 1'b0;

  max_count_sched dut (
    .clock (clock), .reset_(reset_),
    .rfd_a (rfd_a), .dav_a (dav_a), .xa(xa), .ya(ya),
    .rfd_b (rfd_b), .dav_b (dav_b), .xb(xb), .yb(yb),
    .out_a (out_a), .out_b (out_b), .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic int max8(input logic [7:0] x, input logic [7:0] y);
    return (x > y) ? int'(x) : int'(y);
  endfunction

  task automatic finish_service();
    m_pri  = (m_pend == 0);
    m_pend = -1;
    m_rel  = 1'b0;
  endtask

  task automatic model_step();
    if (reset_ !== 1'b1) begin
      m_pend = -1; m_rel = 1'b0; m_left = 0; m_pri = 1'b0;
    end else if (m_pend < 0) begin
      if (dav_a || dav_b) begin
        m_pend = (dav_a && dav_b) ? int'(m_pri) : (dav_b ? 1 : 0);
        m_left = (m_pend == 0) ? max8(xa, ya) : max8(xb, yb);
        m_rel  = 1'b0;
      end
    end else if (!m_rel) begin
      if (!((m_pend == 0) ? dav_a : dav_b)) begin
        m_rel = 1'b1;
        if (m_left == 0) finish_service();
      end
    end else begin
      m_left--;
      if (m_left == 0) finish_service();
    end
  endtask

  // Compare process: advance the model on each edge, check outputs 1 time unit later.
  always begin
    logic [4:0] exp_v, got_v;
    @(posedge clock);
    model_step();
    #1;
    exp_v = {m_pend < 0, m_pend < 0, m_pend == 0 && m_rel, m_pend == 1 && m_rel, m_pend >= 0};
    got_v = {rfd_a, rfd_b, out_a, out_b, busy};
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL cycle_outputs t=%0t {rfd_a,rfd_b,out_a,out_b,busy} got=%b expected=%b",
               $time, got_v, exp_v);
    end
    if (out_a === 1'b1) pulses_a++;
    if (out_b === 1'b1) pulses_b++;
    if (out_a === 1'b1 && prev_a !== 1'b1) order = order * 4 + 1;
    if (out_b === 1'b1 && prev_b !== 1'b1) order = order * 4 + 2;
    prev_a = out_a;
    prev_b = out_b;
  end

  task automatic check(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, expv);
    end
  endtask

  // One cycle of requester behaviour: a granted requester drops dav after its hold time.
  task automatic step();
    @(negedge clock);
    if (dav_a && m_pend == 0 && !m_rel) begin
      if (hold_a > 0) begin
        hold_a--;
        if (scramble) begin xa = 8'($urandom); ya = 8'($urandom); end
      end else dav_a = 1'b0;
    end
    if (dav_b && m_pend == 1 && !m_rel) begin
      if (hold_b > 0) begin
        hold_b--;
        if (scramble) begin xb = 8'($urandom); yb = 8'($urandom); end
      end else dav_b = 1'b0;
    end
  endtask

  task automatic req_a(input logic [7:0] x, input logic [7:0] y, input int h);
    xa = x; ya = y; hold_a = h; dav_a = 1'b1;
  endtask

  task automatic req_b(input logic [7:0] x, input logic [7:0] y, input int h);
    xb = x; yb = y; hold_b = h; dav_b = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((m_pend >= 0 || dav_a || dav_b) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL drain_timeout got=%0d cycles expected<%0d", n, budget);
    end
  endtask

  task automatic pulse_reset();
    reset_ = 1'b0;
    step();
    reset_ = 1'b1;
  endtask

  initial begin
    int ba, bb, bo, n;
    reset_ = 1'b0;
    dav_a = 1'b0; dav_b = 1'b0;
    xa = 8'd0; ya = 8'd0; xb = 8'd0; yb = 8'd0;
    repeat (2) @(negedge clock);
    check("reset_rfd_a", int'(rfd_a), 1);
    check("reset_rfd_b", int'(rfd_b), 1);
    check("reset_out_a", int'(out_a), 0);
    check("reset_out_b", int'(out_b), 0);
    check("reset_busy", int'(busy), 0);
    reset_ = 1'b1;

    // Single requester: max(3,5) = 5 pulses on A only.
    step();
    ba = pulses_a; bb = pulses_b;
    req_a(8'd3, 8'd5, 0);
    drain(200);
    check("single_pulses_a", pulses_a - ba, 5);
    check("single_pulses_b", pulses_b - bb, 0);
    check("single_rfd_back", int'(rfd_a & rfd_b), 1);

    // Contention after reset: A first (2 pulses), then B (4 pulses).
    pulse_reset();
    ba = pulses_a; bb = pulses_b; bo = order;
    req_a(8'd2, 8'd1, 0);
    req_b(8'd0, 8'd4, 0);
    drain(200);
    check("cont_pulses_a", pulses_a - ba, 2);
    check("cont_pulses_b", pulses_b - bb, 4);
    check("cont_order_ab", order - bo * 16, 6);
    bo = order;
    req_a(8'd2, 8'd1, 0);
    req_b(8'd0, 8'd4, 0);
    drain(200);
    check("cont2_order_ab", order - bo * 16, 6);
    bo = order; ba = pulses_a; bb = pulses_b;
    req_a(8'd2, 8'd1, 0);
    drain(200);
    check("cont3_only_a", order - bo * 4, 1);
    check("cont3_pulses_b", pulses_b - bb, 0);

    // Zero count: no pulses even with a late release.
    ba = pulses_a;
    req_a(8'd0, 8'd0, 3);
    drain(200);
    check("zero_pulses_a", pulses_a - ba, 0);

    // Width and compare boundaries.
    bb = pulses_b;
    req_b(8'h80, 8'h7F, 0);
    drain(400);
    check("wide_pulses_b", pulses_b - bb, 128);
    ba = pulses_a;
    req_a(8'hFF, 8'h00, 0);
    drain(400);
    check("max_pulses_a", pulses_a - ba, 255);

    // Late release with operands changing while dav is held.
    ba = pulses_a;
    scramble = 1'b1;
    req_a(8'd3, 8'd7, 10);
    drain(200);
    scramble = 1'b0;
    check("late_pulses_a", pulses_a - ba, 7);

    // Reset in the middle of a pulse train.
    req_a(8'd20, 8'd1, 0);
    n = 0;
    while (out_a !== 1'b1 && n < 100) begin step(); n++; end
    check("midemit_reached", int'(n < 100), 1);
    repeat (3) step();
    reset_ = 1'b0;
    step();
    check("midemit_out_a", int'(out_a), 0);
    check("midemit_rfd_a", int'(rfd_a), 1);
    check("midemit_busy", int'(busy), 0);
    reset_ = 1'b1;

    // Randomised traffic from both requesters.
    for (int i = 0; i < 600; i++) begin
      step();
      if (!dav_a && $urandom_range(3) == 0)
        req_a(8'($urandom_range(($urandom_range(7) == 0) ? 255 : 12)),
              8'($urandom_range(12)), int'($urandom_range(3)));
      if (!dav_b && $urandom_range(3) == 0)
        req_b(8'($urandom_range(12)),
              8'($urandom_range(($urandom_range(7) == 0) ? 255 : 12)), int'($urandom_range(3)));
    end
    drain(2000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/max_count_sched.md
# max_count_sched

Round-robin scheduler that shares one max-and-count unit between two requesters, A and B. Each requester presents an operand pair through an rfd/dav handshake. The block grants one requester and latches the unsigned maximum of its pair. It then drives that requester's out line high for exactly that many clock cycles, and only afterwards accepts new work. It is the two-client successor of the single-client max-count block and sits between two producers and their pulse-consuming logic.

## Interface
- No parameters; all data widths are fixed at 8 bits.
- clock  input  1  system clock; all state changes on the rising edge.
- reset_  input  1  synchronous active-low reset, sampled on the rising edge of clock.
- rfd_a  output  1  ready-for-data to requester A.
- dav_a  input  1  data-valid from requester A.
- xa  input  8  operand x, requester A, unsigned.
- ya  input  8  operand y, requester A, unsigned.
- rfd_b  output  1  ready-for-data to requester B.
- dav_b  input  1  data-valid from requester B.
- xb  input  8  operand x, requester B, unsigned.
- yb  input  8  operand y, requester B, unsigned.
- out_a  output  1  pulse-train output to requester A.
- out_b  output  1  pulse-train output to requester B.
- busy  output  1  high whenever the state is not IDLE.

## Operation
- Internal registers:
  - STAR: state, one of IDLE / WAIT / EMIT.
  - COUNT: 8-bit count.
  - GNT: granted requester, 0 = A, 1 = B.
  - PRI: priority pointer, 0 = A favoured.
  - The rfd and out outputs are each registered.
- Reset (edge with reset_ = 0) sets: STAR = IDLE, rfd_a = rfd_b = 1, out_a = out_b = 0, COUNT = 0, GNT = 0, PRI = 0.
- Reset overrides every other action, including in the middle of an EMIT phase; the pulse train is aborted at that edge.
- IDLE:
  - rfd_a = rfd_b = 1.
  - If neither dav is high, stay in IDLE.
  - If exactly one dav is high, that requester wins.
  - If both dav are high, the requester selected by PRI wins.
  - On a win: GNT <= winner, COUNT <= max(x, y) of the winner, rfd_a <= 0, rfd_b <= 0, go to WAIT.
- max(x, y) is an unsigned 8-bit compare. If x < y the result is y, otherwise x.
- Operands are sampled only at the IDLE grant edge. They may change freely afterwards.
- The losing requester keeps its dav and data asserted. It is served at the next IDLE, since PRI then favours it.
- WAIT: stay until the granted requester's dav is low. The other requester's dav is ignored. When the granted dav is low:
  - If COUNT = 0: rfd_a <= rfd_b <= 1, PRI <= ~GNT, go to IDLE. No pulses are emitted.
  - Otherwise: out_GNT <= 1, go to EMIT, COUNT unchanged.
- EMIT, evaluated on each edge:
  - If COUNT = 1: out_GNT <= 0, rfd_a <= rfd_b <= 1, PRI <= ~GNT, go to IDLE.
  - Otherwise: COUNT <= COUNT - 1.
  - COUNT never wraps, because COUNT = 0 never enters EMIT.
- The out line of the non-granted requester is 0 at all times.
- busy is decoded directly from STAR and has no extra register stage.

## Timing
- Grant: dav sampled high at edge n → rfd_a and rfd_b low and busy high after edge n.
- Release: granted dav first sampled low at edge m.
  - COUNT = N > 0: out_GNT high from edge m to edge m+N, i.e. exactly N cycles. rfd lines and busy return at edge m+N.
  - COUNT = 0: rfd lines and busy return at edge m.
- Back-to-back service: when the other requester's dav is still high, its grant happens at the edge immediately after the return to IDLE. Each grant→release costs at least one IDLE cycle.
- Maximum pulse train: 255 cycles. Minimum service turnaround: 2 cycles plus COUNT.
- All outputs are registered or decoded from registers. There is no combinational path from any input to any output.

## Test plan
- Reset check: hold reset_ = 0 for 2 edges → rfd_a = rfd_b = 1, out_a = out_b = 0, busy = 0. Assert reset_ = 0 mid-EMIT → out drops and rfd returns to 1 at that edge.
- Single requester: xa = 3, ya = 5, dav_a = 1 for one edge, then 0 → both rfd low at the next edge. out_a is then high for exactly 5 cycles. out_b stays 0, then rfd returns to 1.
- Contention: both dav rise at the same edge after reset, with xa = 2, ya = 1, xb = 0, yb = 4 and dav_b held high → A is served first with 2 pulses on out_a. B is granted at the next IDLE edge and gets 4 pulses on out_b. Repeat the contention → B's turn is skipped only if dav_b is low; otherwise service alternates.
- Zero count: xa = ya = 0 → no out_a pulse. rfd returns at the first edge where dav_a is low.
- Width/compare: xb = 0x80, yb = 0x7F → 128 pulses. Then xa = 0xFF, ya = 0x00 → 255 pulses, with no wrap.
- Late release: hold dav_a high for 10 cycles after the grant, and change xa/ya during that time → out stays low until dav_a falls. The pulse count equals the maximum sampled at the grant edge.
